sample_pairer: RTL and testbench
================================

SAMPLE_PAIRER -- requirements
Module: sample_pairer

Interface
REQ-001 Parameter G_DATA_SIZE, default 10, SHALL set the sample width in bits.
REQ-002 Parameter G_CNT_SIZE, default 16, SHALL set the pair counter width in bits.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 s_data  in  G_DATA_SIZE  SHALL carry the input sample (unsigned).
REQ-006 s_valid  in  1  SHALL mark s_data as valid.
REQ-007 s_ready  out  1  SHALL indicate the block accepts a sample this cycle.
REQ-008 flush  in  1  SHALL be a synchronous request to discard any unpaired sample.
REQ-009 a_out  out  G_DATA_SIZE  SHALL carry the older sample of the presented pair; it feeds the averager's a_in.
REQ-010 b_out  out  G_DATA_SIZE  SHALL carry the newer sample of the presented pair; it feeds the averager's b_in.
REQ-011 pair_valid  out  1  SHALL mark a_out/b_out as a valid pair.
REQ-012 pair_ready  in  1  SHALL indicate the consumer takes the pair this cycle.
REQ-013 pair_count  out  G_CNT_SIZE  SHALL count the pairs handed off.

Function
REQ-014 A sample transfer SHALL occur when s_valid and s_ready are both 1; a pair transfer SHALL occur when pair_valid and pair_ready are both 1.
REQ-015 The FSM SHALL have the states EMPTY (no sample held), HALF (one sample held in a_out) and FULL (pair held, pair_valid=1).
REQ-016 pair_valid SHALL be 1 exactly in FULL, driven from a register.
REQ-017 s_ready SHALL be 1 in EMPTY and HALF; in FULL it SHALL equal pair_ready, so a pair transfer and a sample transfer can occur in the same cycle.
REQ-018 EMPTY + sample transfer SHALL load a_out and move to HALF.
REQ-019 HALF + sample transfer SHALL load b_out and move to FULL, so pair_valid rises one cycle after the second sample.
REQ-020 FULL + pair transfer without a sample transfer SHALL move to EMPTY (disjoint mode) or HALF with a_out<=b_out (sliding mode).
REQ-021 FULL + simultaneous pair and sample transfer SHALL move to HALF with a_out<=new sample (disjoint mode) or stay in FULL with a_out<=b_out, b_out<=new sample (sliding mode).
REQ-022 a_out/b_out SHALL stay stable while pair_valid=1 and pair_ready=0.
REQ-023 flush in HALF SHALL move to EMPTY, and a same-cycle sample transfer SHALL be discarded; flush in EMPTY or FULL SHALL have no effect.
REQ-024 pair_count SHALL increment by 1 per pair transfer and wrap from all-ones to 0.
REQ-025 The sample throughput SHALL be one sample per cycle when pair_ready is held at 1.

Reset
REQ-026 reset_n=0 SHALL immediately force EMPTY, a_out=0, b_out=0, pair_valid=0 and pair_count=0; s_ready SHALL be 1 from the first cycle after release.
REQ-027 Reset asserted mid-pair SHALL lose the held samples without producing a pair.

Configuration
REQ-028 With macro SAMPLE_PAIRER_SLIDING_EN defined, the block SHALL produce overlapping pairs (x0,x1),(x1,x2),... as in REQ-020/021 sliding mode.
REQ-029 With SAMPLE_PAIRER_SLIDING_EN undefined, the block SHALL produce disjoint pairs (x0,x1),(x2,x3),..., and the sliding logic SHALL be absent.

Structure
REQ-030 The package sample_pairer_pkg SHALL hold the FSM state enum (ST_EMPTY, ST_HALF, ST_FULL) and the default width constants.
REQ-031 The block SHALL be a single module with no sub-module; the FSM and datapath SHALL sit in one clocked process with an asynchronous reset branch.

Verification
REQ-032 Disjoint mode: samples 3,5,7,9 with pair_ready=1 -> pairs (3,5) then (7,9); pair_count=2.
REQ-033 Sliding mode: samples 3,5,7,9 with pair_ready=1 -> pairs (3,5),(5,7),(7,9); pair_count=3.
REQ-034 Backpressure: pair_ready=0 for 4 cycles in FULL holding (10,20) -> s_ready=0, outputs held at (10,20); the pair is released on the first cycle pair_ready=1.
REQ-035 flush in HALF holding 42, then samples 1,2 -> the single pair (1,2); 42 never appears on a_out with pair_valid=1.
REQ-036 G_CNT_SIZE=4: 17 pair transfers -> pair_count wraps through 15 to 0 and ends at 1.
REQ-037 reset_n pulsed low while FULL holding (1023,1023) -> pair_valid=0 and outputs 0 immediately, pair_count=0; the next samples 0,1 give pair (0,1).

Source files
------------

// File: rtl/sample_pairer_pkg.sv
// Shared FSM state encoding and default widths for the sample pairer.
package sample_pairer_pkg;

    localparam int DEF_DATA_SIZE = 10;
    localparam int DEF_CNT_SIZE  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/sample_pairer.sv
// Groups a sample stream into (older, newer) pairs for a two-input averager, 0-cycle accept / 1-cycle pair latency.
// Stalls input only while a pair is held and the consumer is not ready; SAMPLE_PAIRER_SLIDING_EN selects overlapping pairs.
module sample_pairer
    import sample_pairer_pkg::*;
#(
    parameter int G_DATA_SIZE = DEF_DATA_SIZE,
    parameter int G_CNT_SIZE  = DEF_CNT_SIZE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [G_DATA_SIZE-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   flush,
    output logic [G_DATA_SIZE-1:0] a_out,
    output logic [G_DATA_SIZE-1:0] b_out,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic [G_CNT_SIZE-1:0]  pair_count
);

    state_e                 state_q, state_d;
    logic [G_DATA_SIZE-1:0] a_q, a_d;
    logic [G_DATA_SIZE-1:0] b_q, b_d;
    logic                   pv_q, pv_d;
    logic [G_CNT_SIZE-1:0]  cnt_q, cnt_d;

    logic s_xfer;
    logic p_xfer;

    // A held pair may be consumed and replaced in the same cycle.
    assign s_ready = (state_q != ST_FULL) || pair_ready;
    assign s_xfer  = s_valid && s_ready;
    assign p_xfer  = pv_q && pair_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (s_xfer) begin
                    a_d     = s_data;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (s_xfer) begin
                    b_d     = s_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (p_xfer) begin
`ifdef SAMPLE_PAIRER_SLIDING_EN
                    a_d = b_q;
                    if (s_xfer) begin
                        b_d     = s_data;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_HALF;
                    end
`else
                    if (s_xfer) begin
                        a_d     = s_data;
                        state_d = ST_HALF;
                    end else begin
                        state_d = ST_EMPTY;
                    end
`endif
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        pv_d  = (state_d == ST_FULL);
        cnt_d = cnt_q + {{(G_CNT_SIZE-1){1'b0}}, p_xfer};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            pv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pv_q    <= pv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign pair_valid = pv_q;
    assign pair_count = cnt_q;

endmodule

// File: tb/tb_sample_pairer.sv
// Directed-vector bench for sample_pairer; expectations follow the mode chosen by SAMPLE_PAIRER_SLIDING_EN.
module tb_sample_pairer;

    localparam int DW = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          flush = 1'b0;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          pair_valid;
    logic          pair_ready = 1'b0;
    logic [CW-1:0] pair_count;

    int total = 0;
    int bad   = 0;
    logic [2*DW-1:0] pairs[$];
    logic [2*DW-1:0] exp_pairs[$];
    bit saw42 = 1'b0;

    sample_pairer #(.G_DATA_SIZE(DW), .G_CNT_SIZE(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .flush      (flush),
        .a_out      (a_out),
        .b_out      (b_out),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    // Record every pair handoff that the next rising edge will complete.
    always @(negedge clk) begin
        if (reset_n && pair_valid && pair_ready) pairs.push_back({a_out, b_out});
        if (reset_n && pair_valid && a_out == 10'd42) saw42 = 1'b1;
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic pr, input logic fl);
        s_valid = v; s_data = d; pair_ready = pr; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        s_valid = 0; s_data = '0; pair_ready = 0; flush = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
        pairs.delete();
    endtask

    task automatic check_pairs(input string name);
        total++;
        if (pairs.size() != exp_pairs.size()) begin
            bad++;
            $display("FAIL %s pair_count_seen: got %0d want %0d", name, pairs.size(), exp_pairs.size());
        end
        for (int k = 0; k < exp_pairs.size(); k++) begin
            total++;
            if (k >= pairs.size() || pairs[k] !== exp_pairs[k]) begin
                bad++;
                $display("FAIL %s pair[%0d]: got %h want %h", name, k,
                         (k < pairs.size()) ? pairs[k] : 20'hx, exp_pairs[k]);
            end
        end
    endtask

    task automatic test_reset();
        s_valid = 0; pair_ready = 0; flush = 0;
        reset_n = 0;
        #3;
        total++;
        if ({pair_valid, a_out, b_out, pair_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got pv=%b a=%0d b=%0d cnt=%0d want all 0", pair_valid, a_out, b_out, pair_count);
        end
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic test_pairing();
        do_reset();
        exp_pairs.delete();
        cyc(1, 3, 1, 0);
        cyc(1, 5, 1, 0);
        total++;
        if (pair_valid !== 1'b1 || a_out !== 10'd3 || b_out !== 10'd5) begin
            bad++;
            $display("FAIL first_pair_latency: got pv=%b a=%0d b=%0d want pv=1 a=3 b=5", pair_valid, a_out, b_out);
        end
        cyc(1, 7, 1, 0);
        cyc(1, 9, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        exp_pairs.push_back({10'd3, 10'd5});
`ifdef SAMPLE_PAIRER_SLIDING_EN
        exp_pairs.push_back({10'd5, 10'd7});
`endif
        exp_pairs.push_back({10'd7, 10'd9});
        check_pairs("pairing");
        total++;
        if (pair_count !== CW'(exp_pairs.size())) begin
            bad++;
            $display("FAIL pairing_count: got %0d want %0d", pair_count, exp_pairs.size());
        end
        total++;
        if (pair_valid !== 1'b0) begin
            bad++;
            $display("FAIL pairing_drained: got pv=%b want 0", pair_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        exp_pairs.delete();
        cyc(1, 10, 0, 0);
        cyc(1, 20, 0, 0);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 30; pair_ready = 0;
            #1;
            total++;
            if (s_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_s_ready[%0d]: got %b want 0", i, s_ready);
            end
            @(posedge clk); #1;
            total++;
            if (pair_valid !== 1'b1 || a_out !== 10'd10 || b_out !== 10'd20) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got pv=%b a=%0d b=%0d want pv=1 a=10 b=20", i, pair_valid, a_out, b_out);
            end
        end
        s_valid = 0; pair_ready = 1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_s_ready: got %b want 1", s_ready);
        end
        @(posedge clk); #1;
        total++;
        if (pair_valid !== 1'b0 || pair_count !== 4'd1) begin
            bad++;
            $display("FAIL bp_release: got pv=%b cnt=%0d want pv=0 cnt=1", pair_valid, pair_count);
        end
        exp_pairs.push_back({10'd10, 10'd20});
        check_pairs("backpressure");
    endtask

    task automatic test_flush();
        do_reset();
        exp_pairs.delete();
        saw42 = 1'b0;
        cyc(1, 42, 1, 1);
        total++;
        if (a_out !== 10'd42 || pair_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_in_empty: got a=%0d pv=%b want a=42 pv=0", a_out, pair_valid);
        end
        cyc(1, 99, 1, 1);
        cyc(1, 1, 1, 0);
        cyc(1, 2, 1, 0);
        total++;
        if (pair_valid !== 1'b1 || a_out !== 10'd1 || b_out !== 10'd2) begin
            bad++;
            $display("FAIL flush_next_pair: got pv=%b a=%0d b=%0d want pv=1 a=1 b=2", pair_valid, a_out, b_out);
        end
        cyc(0, 0, 0, 1);
        total++;
        if (pair_valid !== 1'b1 || a_out !== 10'd1 || b_out !== 10'd2) begin
            bad++;
            $display("FAIL flush_in_full: got pv=%b a=%0d b=%0d want pv=1 a=1 b=2", pair_valid, a_out, b_out);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        exp_pairs.push_back({10'd1, 10'd2});
        check_pairs("flush");
        total++;
        if (saw42 !== 1'b0) begin
            bad++;
            $display("FAIL flush_42_leak: got saw42=%b want 0", saw42);
        end
    endtask

    task automatic test_wrap();
        int n;
        bit seen_wrap;
        logic [CW-1:0] prev;
        do_reset();
`ifdef SAMPLE_PAIRER_SLIDING_EN
        n = 18;
`else
        n = 34;
`endif
        seen_wrap = 0;
        prev = pair_count;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) cyc(1, DW'(i + 100), 1, 0);
            else       cyc(0, 0, 1, 0);
            if (prev == 4'd15 && pair_count == 4'd0) seen_wrap = 1;
            prev = pair_count;
        end
        total++;
        if (seen_wrap !== 1'b1) begin
            bad++;
            $display("FAIL wrap_15_to_0: got seen=%b want 1", seen_wrap);
        end
        total++;
        if (pair_count !== 4'd1 || pairs.size() != 17) begin
            bad++;
            $display("FAIL wrap_end: got cnt=%0d pairs=%0d want cnt=1 pairs=17", pair_count, pairs.size());
        end
    endtask

    task automatic test_reset_midpair();
        do_reset();
        exp_pairs.delete();
        cyc(1, 1023, 0, 0);
        cyc(1, 1023, 0, 0);
        total++;
        if (pair_valid !== 1'b1 || a_out !== 10'd1023 || b_out !== 10'd1023) begin
            bad++;
            $display("FAIL midreset_full: got pv=%b a=%0d b=%0d want pv=1 a=1023 b=1023", pair_valid, a_out, b_out);
        end
        s_valid = 0;
        #2 reset_n = 0;
        #1;
        total++;
        if ({pair_valid, a_out, b_out, pair_count} !== '0) begin
            bad++;
            $display("FAIL midreset_async: got pv=%b a=%0d b=%0d cnt=%0d want all 0", pair_valid, a_out, b_out, pair_count);
        end
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        total++;
        if (pair_valid !== 1'b1 || a_out !== 10'd0 || b_out !== 10'd1) begin
            bad++;
            $display("FAIL midreset_next: got pv=%b a=%0d b=%0d want pv=1 a=0 b=1", pair_valid, a_out, b_out);
        end
        cyc(0, 0, 1, 0);
        exp_pairs.push_back({10'd0, 10'd1});
        check_pairs("midreset");
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_midpair();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
